// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction-fetch port, the load/store port and the shared memory port.
// The arbiter takes the slave view; the core and memory environment take the master view.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single-outstanding memory port.
// Data has priority, bounded by a starvation counter that eventually forces a fetch.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          resetn,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             lock_q, lock_d;
    logic             lock_sel_q, lock_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_win;
    logic             req;
    logic             i_gnt, d_gnt, i_rvalid, d_rvalid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            cnt_q      <= cnt_d;
        end
    end

    // A presented-but-ungranted request keeps its winner until memory accepts it.
    always_comb begin
        if (lock_q) data_win = lock_sel_q;
        else        data_win = bus.d_req && !(bus.i_req && (cnt_q == LIMIT));
    end

    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        req        = 1'b0;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        i_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        case (state_q)
            IDLE: begin
                req = bus.i_req | bus.d_req;
                if (req && bus.mem_gnt) begin
                    i_gnt   = !data_win;
                    d_gnt   = data_win;
                    state_d = data_win ? WAIT_D : WAIT_I;
                    lock_d  = 1'b0;
                end else if (req) begin
                    lock_d     = 1'b1;
                    lock_sel_d = data_win;
                end
            end
            WAIT_I: begin
                if (bus.mem_rvalid) begin
                    i_rvalid = 1'b1;
                    state_d  = IDLE;
                end
            end
            WAIT_D: begin
                if (bus.mem_rvalid) begin
                    d_rvalid = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!bus.i_req || i_gnt)
            cnt_d = '0;
        else if (d_gnt && (cnt_q != LIMIT))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Handshake outputs are forced low while reset is held, regardless of inputs.
    assign bus.mem_req   = req & resetn;
    assign bus.i_gnt     = i_gnt & resetn;
    assign bus.d_gnt     = d_gnt & resetn;
    assign bus.i_rvalid  = i_rvalid & resetn;
    assign bus.d_rvalid  = d_rvalid & resetn;

    assign bus.mem_we    = data_win & bus.d_we;
    assign bus.mem_be    = data_win ? bus.d_be    : 4'hF;
    assign bus.mem_addr  = data_win ? bus.d_addr  : bus.i_addr;
    assign bus.mem_wdata = data_win ? bus.d_wdata : 32'h0;

    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int NGRANTS      = 12;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [4:0] ctl();
        return {bus.mem_req, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid};
    endfunction

    function automatic logic [68:0] fields();
        return {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
    endfunction

    task automatic idle_bus();
        bus.i_req = 1'b0; bus.i_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0;
        bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        idle_bus();
        resetn = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1; bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1;
        sample();
        checks++;
        if (ctl() !== 5'b00000) begin
            errors++; $display("FAIL reset_outputs ctl=%b want=%b", ctl(), 5'b00000);
        end
        tick();
        resetn = 1'b1;
        bus.d_req = 1'b0; bus.mem_rvalid = 1'b0; bus.i_addr = 32'h0000_1000;
        sample();
        checks++;
        if (ctl() !== 5'b11000) begin
            errors++; $display("FAIL reset_first_grant ctl=%b want=%b", ctl(), 5'b11000);
        end
        tick();
        bus.i_req = 1'b0; bus.mem_gnt = 1'b0;
        tick();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
        sample();
        checks++;
        if (ctl() !== 5'b00010) begin
            errors++; $display("FAIL reset_first_resp ctl=%b want=%b", ctl(), 5'b00010);
        end
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_lone_fetch();
        idle_bus();
        bus.d_addr = 32'h0000_4444; bus.d_wdata = 32'hA5A5_5A5A; bus.d_be = 4'h1;
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_2000; bus.mem_gnt = 1'b1;
        sample();
        checks++;
        if (ctl() !== 5'b11000) begin
            errors++; $display("FAIL lone_fetch_gnt ctl=%b want=%b", ctl(), 5'b11000);
        end
        checks++;
        if (fields() !== {1'b0, 4'hF, 32'h0000_2000, 32'h0}) begin
            errors++; $display("FAIL lone_fetch_fields got=%h want=%h", fields(), {1'b0, 4'hF, 32'h0000_2000, 32'h0});
        end
        tick();
        bus.i_req = 1'b0; bus.mem_gnt = 1'b0;
        sample();
        checks++;
        if (ctl() !== 5'b00000) begin
            errors++; $display("FAIL lone_fetch_wait ctl=%b want=%b", ctl(), 5'b00000);
        end
        tick();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0013;
        sample();
        checks++;
        if (ctl() !== 5'b00010) begin
            errors++; $display("FAIL lone_fetch_rvalid ctl=%b want=%b", ctl(), 5'b00010);
        end
        checks++;
        if (bus.i_rdata !== 32'h0000_0013) begin
            errors++; $display("FAIL lone_fetch_rdata got=%h want=%h", bus.i_rdata, 32'h0000_0013);
        end
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_priority();
        idle_bus();
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_3000;
        bus.d_req = 1'b1; bus.d_addr = 32'h0000_8000; bus.mem_gnt = 1'b1;
        sample();
        checks++;
        if (ctl() !== 5'b10100 || bus.mem_addr !== 32'h0000_8000) begin
            errors++; $display("FAIL prio_data_first ctl=%b addr=%h want=%b addr=%h", ctl(), bus.mem_addr, 5'b10100, 32'h0000_8000);
        end
        tick();
        bus.d_req = 1'b0;
        sample();
        checks++;
        if (ctl() !== 5'b00000) begin
            errors++; $display("FAIL prio_wait_d_gnt_ignored ctl=%b want=%b", ctl(), 5'b00000);
        end
        tick();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
        sample();
        checks++;
        if (ctl() !== 5'b00001 || bus.d_rdata !== 32'hCAFE_0001) begin
            errors++; $display("FAIL prio_d_resp ctl=%b rdata=%h want=%b rdata=%h", ctl(), bus.d_rdata, 5'b00001, 32'hCAFE_0001);
        end
        tick();
        bus.mem_rvalid = 1'b0;
        sample();
        checks++;
        if (ctl() !== 5'b11000 || bus.mem_addr !== 32'h0000_3000) begin
            errors++; $display("FAIL prio_fetch_next ctl=%b addr=%h want=%b addr=%h", ctl(), bus.mem_addr, 5'b11000, 32'h0000_3000);
        end
        tick();
        bus.i_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1;
        sample();
        checks++;
        if (ctl() !== 5'b00010) begin
            errors++; $display("FAIL prio_i_resp ctl=%b want=%b", ctl(), 5'b00010);
        end
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_lock();
        idle_bus();
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_5000; bus.d_addr = 32'h0000_9000;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bus.d_req = 1'b1;
            sample();
            checks++;
            if (ctl() !== 5'b10000 || bus.mem_addr !== 32'h0000_5000) begin
                errors++; $display("FAIL lock_hold_c%0d ctl=%b addr=%h want=%b addr=%h", c, ctl(), bus.mem_addr, 5'b10000, 32'h0000_5000);
            end
            tick();
        end
        bus.mem_gnt = 1'b1;
        sample();
        checks++;
        if (ctl() !== 5'b11000 || bus.mem_addr !== 32'h0000_5000) begin
            errors++; $display("FAIL lock_grant ctl=%b addr=%h want=%b addr=%h", ctl(), bus.mem_addr, 5'b11000, 32'h0000_5000);
        end
        tick();
        bus.i_req = 1'b0; bus.mem_gnt = 1'b0;
        tick();
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b1;
        sample();
        checks++;
        if (ctl() !== 5'b10100 || bus.mem_addr !== 32'h0000_9000) begin
            errors++; $display("FAIL lock_then_data ctl=%b addr=%h want=%b addr=%h", ctl(), bus.mem_addr, 5'b10100, 32'h0000_9000);
        end
        tick();
        bus.d_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_store();
        idle_bus();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
        bus.d_addr = 32'h0000_0C40; bus.d_wdata = 32'hDEAD_BEEF; bus.mem_gnt = 1'b1;
        bus.i_addr = 32'h0000_7777;
        sample();
        checks++;
        if (ctl() !== 5'b10100) begin
            errors++; $display("FAIL store_gnt ctl=%b want=%b", ctl(), 5'b10100);
        end
        checks++;
        if (fields() !== {1'b1, 4'b0011, 32'h0000_0C40, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL store_fields got=%h want=%h", fields(), {1'b1, 4'b0011, 32'h0000_0C40, 32'hDEAD_BEEF});
        end
        tick();
        bus.d_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1;
        sample();
        checks++;
        if (ctl() !== 5'b00001) begin
            errors++; $display("FAIL store_ack ctl=%b want=%b", ctl(), 5'b00001);
        end
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_starvation();
        int  order[$];
        int  gcyc[$];
        int  cnt = 0;
        bit  gprev = 1'b0;
        bit  exp_d;
        idle_bus();
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0100;
        bus.d_req = 1'b1; bus.d_addr = 32'h0000_0200; bus.mem_gnt = 1'b1;
        for (int c = 0; c < 40 && order.size() < NGRANTS; c++) begin
            if (c > 0) begin
                tick();
                bus.mem_rvalid = gprev;
            end
            sample();
            gprev = bus.i_gnt | bus.d_gnt;
            if (bus.i_gnt) order.push_back(0);
            if (bus.d_gnt) order.push_back(1);
            if (gprev) gcyc.push_back(c);
        end
        checks++;
        if (order.size() != NGRANTS) begin
            errors++; $display("FAIL starve_grant_count got=%0d want=%0d", order.size(), NGRANTS);
        end
        // Data wins until it has been granted STARVE_LIMIT times in a row over a waiting fetch.
        for (int k = 0; k < order.size(); k++) begin
            exp_d = (cnt != STARVE_LIMIT);
            cnt   = exp_d ? cnt + 1 : 0;
            checks++;
            if (order[k] != int'(exp_d)) begin
                errors++; $display("FAIL starve_order_%0d got=%0d want=%0d (1=data)", k, order[k], exp_d);
            end
        end
        for (int k = 1; k < gcyc.size(); k++) begin
            checks++;
            if (gcyc[k] - gcyc[k-1] != 2) begin
                errors++; $display("FAIL starve_throughput_%0d gap=%0d want=2", k, gcyc[k] - gcyc[k-1]);
            end
        end
        tick();
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = gprev;
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        idle_bus();
        bus.d_req = 1'b1; bus.d_addr = 32'h0000_0A00; bus.mem_gnt = 1'b1;
        sample();
        checks++;
        if (ctl() !== 5'b10100) begin
            errors++; $display("FAIL rstmid_gnt ctl=%b want=%b", ctl(), 5'b10100);
        end
        tick();
        bus.d_req = 1'b0; bus.mem_gnt = 1'b0;
        tick();
        resetn = 1'b0;
        bus.i_req = 1'b1; bus.mem_gnt = 1'b1;
        sample();
        checks++;
        if (ctl() !== 5'b00000) begin
            errors++; $display("FAIL rstmid_held ctl=%b want=%b", ctl(), 5'b00000);
        end
        tick();
        resetn = 1'b1;
        bus.i_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        sample();
        checks++;
        if (ctl() !== 5'b00000) begin
            errors++; $display("FAIL rstmid_late_rvalid ctl=%b want=%b", ctl(), 5'b00000);
        end
        tick();
        bus.mem_rvalid = 1'b0; bus.i_req = 1'b1; bus.i_addr = 32'h0000_0B00; bus.mem_gnt = 1'b1;
        sample();
        checks++;
        if (ctl() !== 5'b11000) begin
            errors++; $display("FAIL rstmid_next_fetch ctl=%b want=%b", ctl(), 5'b11000);
        end
        tick();
        bus.i_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1;
        sample();
        checks++;
        if (ctl() !== 5'b00010) begin
            errors++; $display("FAIL rstmid_fetch_resp ctl=%b want=%b", ctl(), 5'b00010);
        end
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_random(input int ncycles);
        int          outq[$];
        int          starve = 0;
        int          resp_cnt = -1;
        bit          locked = 1'b0, lock_port = 1'b0;
        bit          ig_prev = 1'b0, dg_prev = 1'b0;
        bit          exp_req, win, e_ig, e_dg, e_ir, e_dr;
        logic [68:0] exp_f;
        idle_bus();
        for (int n = 0; n < ncycles; n++) begin
            if (n > 0) tick();
            if (resp_cnt > 0) resp_cnt--;
            if (resp_cnt == 0) begin
                bus.mem_rvalid = 1'b1;
                resp_cnt = -1;
            end else begin
                bus.mem_rvalid = (resp_cnt < 0) && ($urandom_range(0, 7) == 0);
            end
            bus.mem_rdata = $urandom;
            bus.mem_gnt   = ($urandom_range(0, 9) < 6);
            if (!bus.i_req || ig_prev) begin
                bus.i_req  = 1'($urandom_range(0, 1));
                bus.i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!bus.d_req || dg_prev) begin
                bus.d_req   = 1'($urandom_range(0, 1));
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_be    = 4'($urandom);
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
            end
            sample();
            exp_req = (outq.size() == 0) && (bus.i_req || bus.d_req);
            win     = locked ? lock_port : (bus.d_req && !(bus.i_req && starve >= STARVE_LIMIT));
            e_ig    = exp_req && bus.mem_gnt && !win;
            e_dg    = exp_req && bus.mem_gnt && win;
            e_ir    = (outq.size() > 0) && bus.mem_rvalid && (outq[0] == 0);
            e_dr    = (outq.size() > 0) && bus.mem_rvalid && (outq[0] == 1);
            checks++;
            if (ctl() !== {exp_req, e_ig, e_dg, e_ir, e_dr}) begin
                errors++; $display("FAIL rand_ctl_c%0d ctl=%b want=%b", n, ctl(), {exp_req, e_ig, e_dg, e_ir, e_dr});
            end
            if (exp_req) begin
                exp_f = win ? {bus.d_we, bus.d_be, bus.d_addr, bus.d_wdata}
                            : {1'b0, 4'hF, bus.i_addr, 32'h0};
                checks++;
                if (fields() !== exp_f) begin
                    errors++; $display("FAIL rand_fields_c%0d got=%h want=%h", n, fields(), exp_f);
                end
            end
            if (e_ir || e_dr) begin
                checks++;
                if ((e_ir ? bus.i_rdata : bus.d_rdata) !== bus.mem_rdata) begin
                    errors++; $display("FAIL rand_rdata_c%0d got=%h want=%h", n, e_ir ? bus.i_rdata : bus.d_rdata, bus.mem_rdata);
                end
                void'(outq.pop_front());
            end
            if (e_ig || e_dg) begin
                outq.push_back(int'(win));
                locked   = 1'b0;
                resp_cnt = $urandom_range(1, 3);
            end else if (exp_req) begin
                locked    = 1'b1;
                lock_port = win;
            end
            if (!bus.i_req || e_ig) starve = 0;
            else if (e_dg && starve < STARVE_LIMIT) starve++;
            ig_prev = e_ig;
            dg_prev = e_dg;
        end
        tick();
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (resp_cnt > 0) resp_cnt--;
            bus.mem_rvalid = (resp_cnt == 0);
            if (resp_cnt == 0) resp_cnt = -1;
            tick();
        end
        bus.mem_rvalid = 1'b0;
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        idle_bus();
        test_reset();
        test_lone_fetch();
        test_priority();
        test_lock();
        test_store();
        test_starvation();
        test_reset_mid();
        test_random(2000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
